ctrl_flow_sequencer: RTL and testbench

Front-end driver of the control stack. It accepts decoded structured-control instructions (block, loop, if, end, br, return, call) from the decoder and issues the matching push/pop/function_call commands and frame words. It unwinds multiple frames for `br N` and `return`, one frame per cycle, and hands the resulting jump target and value-stack tag to the fetch and value-stack logic. It sits between the decoder and the control stack and is the only master of the control stack's command port.

---
 rtl/ctrl_flow_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_ctrl_flow_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_flow_sequencer.sv
// Structured-control front end: turns block/loop/if/end/br/return/call into
// control-stack push/pop commands and unwinds frames for br N and return.
module ctrl_flow_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 16,
    parameter int FRAME_W = ADDR_W + TAG_W + 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [2:0]         instr_op,
    input  logic [ADDR_W-1:0]  instr_addr,
    input  logic               instr_ret_num,
    input  logic [TAG_W-1:0]   instr_br_depth,
    input  logic [TAG_W-1:0]   vs_tag,
    output logic               cs_push,
    output logic               cs_pop,
    output logic               cs_function_call,
    output logic [FRAME_W-1:0] cs_push_data,
    input  logic [FRAME_W-1:0] cs_top_data,
    input  logic               cs_left_one,
    output logic               jump_valid,
    output logic [ADDR_W-1:0]  jump_addr,
    output logic [TAG_W-1:0]   jump_tag,
    output logic               jump_ret_num,
    output logic               done,
    output logic               err
);

    localparam int DEPTH_W = $clog2(DEPTH) + 1;

    localparam logic [2:0] OP_BLOCK  = 3'd1;
    localparam logic [2:0] OP_LOOP   = 3'd2;
    localparam logic [2:0] OP_IF     = 3'd3;
    localparam logic [2:0] OP_END    = 3'd4;
    localparam logic [2:0] OP_BR     = 3'd5;
    localparam logic [2:0] OP_RETURN = 3'd6;
    localparam logic [2:0] OP_CALL   = 3'd7;

    localparam logic [1:0] FT_BLOCK = 2'b00;
    localparam logic [1:0] FT_CALL  = 2'b01;
    localparam logic [1:0] FT_IF    = 2'b10;
    localparam logic [1:0] FT_LOOP  = 2'b11;

    typedef enum logic [1:0] {IDLE, UNWIND, RET_UNWIND, HALT} state_t;

    state_t               state, state_nxt;
    logic [DEPTH_W-1:0]   depth;
    logic [TAG_W-1:0]     cnt, cnt_nxt;
    logic                 push_int, pop_int, fcall_int;
    logic [1:0]           push_type;
    logic                 jump_set, done_set, err_set;
    logic                 stack_empty, stack_full;

    logic [1:0]           top_type;
    logic                 top_ret;
    logic [TAG_W-1:0]     top_tag;
    logic [ADDR_W-1:0]    top_addr;

    assign top_type    = cs_top_data[FRAME_W-1 -: 2];
    assign top_ret     = cs_top_data[FRAME_W-3];
    assign top_tag     = cs_top_data[ADDR_W +: TAG_W];
    assign top_addr    = cs_top_data[ADDR_W-1:0];
    assign stack_empty = (depth == '0);
    assign stack_full  = (depth == DEPTH_W'(DEPTH));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        push_int  = 1'b0;
        pop_int   = 1'b0;
        fcall_int = 1'b0;
        push_type = FT_BLOCK;
        jump_set  = 1'b0;
        done_set  = 1'b0;
        err_set   = 1'b0;
        unique case (state)
            IDLE: begin
                if (instr_valid) begin
                    unique case (instr_op)
                        OP_BLOCK, OP_LOOP, OP_IF, OP_CALL: begin
                            if (stack_full) begin
                                err_set = 1'b1;
                            end else begin
                                push_int  = 1'b1;
                                fcall_int = (instr_op == OP_CALL);
                                unique case (instr_op)
                                    OP_LOOP: push_type = FT_LOOP;
                                    OP_IF:   push_type = FT_IF;
                                    OP_CALL: push_type = FT_CALL;
                                    default: push_type = FT_BLOCK;
                                endcase
                            end
                        end
                        OP_END: begin
                            if (stack_empty) begin
                                err_set = 1'b1;
                            end else begin
                                pop_int = 1'b1;
                                if (top_type == FT_CALL) begin
                                    if (cs_left_one) begin
                                        done_set  = 1'b1;
                                        state_nxt = HALT;
                                    end else begin
                                        jump_set = 1'b1;
                                    end
                                end
                            end
                        end
                        OP_BR: begin
                            cnt_nxt   = instr_br_depth;
                            state_nxt = UNWIND;
                        end
                        OP_RETURN: state_nxt = RET_UNWIND;
                        default: ;
                    endcase
                end
            end
            UNWIND: begin
                if (stack_empty) begin
                    err_set = 1'b1;
                end else if (cnt != '0) begin
                    pop_int = 1'b1;
                    cnt_nxt = cnt - TAG_W'(1);
                end else begin
                    // A loop label branches back to its start, so its frame stays.
                    jump_set  = 1'b1;
                    pop_int   = (top_type != FT_LOOP);
                    state_nxt = IDLE;
                end
            end
            RET_UNWIND: begin
                if (stack_empty) begin
                    err_set = 1'b1;
                end else begin
                    pop_int = 1'b1;
                    if (top_type == FT_CALL) begin
                        jump_set = 1'b1;
                        if (cs_left_one) begin
                            done_set  = 1'b1;
                            state_nxt = HALT;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: ;
        endcase
        if (err_set) begin
            state_nxt = HALT;
        end
    end

    // Commands are masked during reset so an in-flight unwind stops immediately.
    assign instr_ready      = (state == IDLE);
    assign cs_push          = push_int & ~rst;
    assign cs_pop           = pop_int & ~rst;
    assign cs_function_call = fcall_int & ~rst;
    assign cs_push_data     = cs_push ? {push_type, instr_ret_num, vs_tag, instr_addr} : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            depth        <= '0;
            cnt          <= '0;
            jump_valid   <= 1'b0;
            jump_addr    <= '0;
            jump_tag     <= '0;
            jump_ret_num <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            jump_valid <= jump_set;
            if (jump_set) begin
                jump_addr    <= top_addr;
                jump_tag     <= top_tag;
                jump_ret_num <= top_ret;
            end
            if (push_int) begin
                depth <= depth + DEPTH_W'(1);
            end else if (pop_int) begin
                depth <= depth - DEPTH_W'(1);
            end
            done <= done | done_set;
            err  <= err | err_set;
        end
    end

endmodule

// File: tb/tb_ctrl_flow_sequencer.sv
// Bench for ctrl_flow_sequencer: a queue-based control stack plus a
// transaction-level reference model predicting pops, jumps, latency and halts.
module tb_ctrl_flow_sequencer;

    localparam int ADDR_W  = 8;
    localparam int TAG_W   = 4;
    localparam int DEPTH   = 16;
    localparam int FRAME_W = ADDR_W + TAG_W + 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               instr_valid = 1'b0;
    logic               instr_ready;
    logic [2:0]         instr_op = '0;
    logic [ADDR_W-1:0]  instr_addr = '0;
    logic               instr_ret_num = 1'b0;
    logic [TAG_W-1:0]   instr_br_depth = '0;
    logic [TAG_W-1:0]   vs_tag = '0;
    logic               cs_push, cs_pop, cs_function_call;
    logic [FRAME_W-1:0] cs_push_data;
    logic [FRAME_W-1:0] cs_top_data = '0;
    logic               cs_left_one = 1'b0;
    logic               jump_valid;
    logic [ADDR_W-1:0]  jump_addr;
    logic [TAG_W-1:0]   jump_tag;
    logic               jump_ret_num;
    logic               done, err;

    ctrl_flow_sequencer #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_addr(instr_addr),
        .instr_ret_num(instr_ret_num), .instr_br_depth(instr_br_depth),
        .vs_tag(vs_tag),
        .cs_push(cs_push), .cs_pop(cs_pop), .cs_function_call(cs_function_call),
        .cs_push_data(cs_push_data), .cs_top_data(cs_top_data),
        .cs_left_one(cs_left_one),
        .jump_valid(jump_valid), .jump_addr(jump_addr), .jump_tag(jump_tag),
        .jump_ret_num(jump_ret_num), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pops_seen = 0, pushes_seen = 0, fcalls_seen = 0;
    int jump_cnt = 0, jcyc = 0;
    logic [ADDR_W-1:0] jaddr_seen = '0;
    logic [TAG_W-1:0]  jtag_seen = '0;
    logic              jret_seen = 1'b0;

    logic [FRAME_W-1:0] q[$];
    logic [FRAME_W-1:0] ref_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Control stack model and command counters.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            q.delete();
        end else begin
            if (cs_pop && q.size() > 0) void'(q.pop_back());
            if (cs_push) q.push_back(cs_push_data);
        end
        if (cs_pop)           pops_seen   <= pops_seen + 1;
        if (cs_push)          pushes_seen <= pushes_seen + 1;
        if (cs_function_call) fcalls_seen <= fcalls_seen + 1;
        cs_top_data <= (q.size() > 0) ? q[q.size()-1] : '0;
        cs_left_one <= (q.size() == 1);
    end

    always @(negedge clk) begin
        if (jump_valid) begin
            jump_cnt   <= jump_cnt + 1;
            jcyc       <= cyc;
            jaddr_seen <= jump_addr;
            jtag_seen  <= jump_tag;
            jret_seen  <= jump_ret_num;
        end
    end

    function automatic logic [FRAME_W-1:0] mk_frame(input int ty, input int ret, input int tag, input int addr);
        return FRAME_W'(ty * 8192 + ret * 4096 + tag * 256 + addr);
    endfunction

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        ref_q.delete();
        @(negedge clk); #1;
        check_val("rst_ready", instr_ready, 1);
        check_val("rst_outs", {jump_valid, done, err, cs_push, cs_pop, cs_function_call}, 0);
        check_val("rst_jaddr", {jump_addr, jump_tag, jump_ret_num}, 0);
    endtask

    // Issue one instruction, predict its effect from the frame list, then compare.
    task automatic exec(input int op, input int addr, input int ret, input int brd, input int tag,
                        output bit halted);
        int t, p0, u0, f0, j0, n, sz, k;
        int e_pops, e_push, e_fc, e_jump, e_lat, e_done, e_err;
        logic [FRAME_W-1:0] f;
        e_pops = 0; e_push = 0; e_fc = 0; e_jump = 0; e_lat = 1; e_done = 0; e_err = 0;
        f = '0;
        sz = ref_q.size();
        case (op)
            1, 2, 3, 7: begin
                if (sz == DEPTH) e_err = 1;
                else begin
                    ref_q.push_back(mk_frame(op == 1 ? 0 : op == 2 ? 3 : op == 3 ? 2 : 1, ret, tag, addr));
                    e_push = 1;
                    e_fc = (op == 7);
                end
            end
            4: begin
                if (sz == 0) e_err = 1;
                else begin
                    f = ref_q.pop_back();
                    e_pops = 1;
                    if ((f >> 13) == 1) begin
                        if (sz == 1) e_done = 1;
                        else e_jump = 1;
                    end
                end
            end
            5: begin
                if (sz < brd + 1) begin
                    e_err = 1; e_pops = sz; e_lat = 2 + sz;
                    ref_q.delete();
                end else begin
                    repeat (brd) void'(ref_q.pop_back());
                    f = ref_q[ref_q.size()-1];
                    e_pops = brd;
                    if ((f >> 13) != 3) begin
                        void'(ref_q.pop_back());
                        e_pops++;
                    end
                    e_jump = 1; e_lat = 2 + brd;
                end
            end
            6: begin
                k = -1;
                for (int i = 0; i < sz; i++) begin
                    if (k < 0 && (ref_q[sz-1-i] >> 13) == 1) k = i;
                end
                if (k < 0) begin
                    e_err = 1; e_pops = sz; e_lat = 2 + sz;
                    ref_q.delete();
                end else begin
                    repeat (k) void'(ref_q.pop_back());
                    f = ref_q.pop_back();
                    e_pops = k + 1; e_jump = 1; e_lat = 2 + k;
                    e_done = (sz == k + 1);
                end
            end
            default: ;
        endcase

        check_val("ready_in", instr_ready, 1);
        instr_op = 3'(op); instr_addr = ADDR_W'(addr); instr_ret_num = ret[0];
        instr_br_depth = TAG_W'(brd); vs_tag = TAG_W'(tag); instr_valid = 1'b1;
        t = cyc; p0 = pops_seen; u0 = pushes_seen; f0 = fcalls_seen; j0 = jump_cnt;
        @(posedge clk); #1 instr_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!(instr_ready || err || done) && n < 80);
        if (n >= 80) check_val("timeout", 1, 0);

        check_val("latency", cyc - t, e_lat);
        check_val("pops", pops_seen - p0, e_pops);
        check_val("pushes", pushes_seen - u0, e_push);
        check_val("fcalls", fcalls_seen - f0, e_fc);
        check_val("jumps", jump_cnt - j0, e_jump);
        if (e_jump != 0) begin
            check_val("jump_cyc", jcyc - t, e_lat);
            check_val("jump_addr", jaddr_seen, f[ADDR_W-1:0]);
            check_val("jump_tag", jtag_seen, f[ADDR_W +: TAG_W]);
            check_val("jump_ret", jret_seen, f[FRAME_W-3]);
        end
        check_val("err", err, e_err);
        check_val("done", done, e_done);
        check_val("depth", q.size(), ref_q.size());
        if (q.size() > 0 && ref_q.size() > 0) check_val("top", q[q.size()-1], ref_q[ref_q.size()-1]);
        halted = (e_err != 0) || (e_done != 0);
        check_val("ready_out", instr_ready, !halted);
    endtask

    initial begin
        bit h;
        int t, p0, op, sz;
        do_reset();
        // Nested constructs closed by END without jumps.
        exec(7, 'h20, 0, 0, 3, h);
        exec(1, 'h30, 1, 0, 4, h);
        exec(2, 'h10, 0, 0, 6, h);
        exec(4, 0, 0, 0, 0, h);
        exec(4, 0, 0, 0, 0, h);
        exec(0, 0, 0, 0, 0, h);

        // BR 0 to a loop, then BR 2 to a block.
        do_reset();
        exec(7, 'h40, 0, 0, 1, h);
        exec(1, 'h50, 1, 0, 2, h);
        exec(1, 'h60, 0, 0, 3, h);
        exec(2, 'h08, 0, 0, 5, h);
        exec(5, 0, 0, 0, 0, h);
        exec(5, 0, 0, 2, 0, h);

        // Nested call returns, the outer one finishes.
        do_reset();
        exec(7, 'h11, 1, 0, 1, h);
        exec(7, 'h22, 0, 0, 2, h);
        exec(1, 'h33, 0, 0, 3, h);
        exec(3, 'h44, 1, 0, 4, h);
        exec(6, 0, 0, 0, 0, h);
        exec(6, 0, 0, 0, 0, h);
        @(negedge clk); #1;
        check_val("halt_ready", instr_ready, 0);

        // Underflow and overflow.
        do_reset();
        exec(4, 0, 0, 0, 0, h);
        do_reset();
        for (int i = 0; i <= DEPTH; i++) exec(1, i, 0, 0, 0, h);

        // Reset in the middle of a long unwind.
        do_reset();
        for (int i = 0; i < 6; i++) exec(i == 0 ? 7 : 1, 'h70 + i, 0, 0, i, h);
        instr_op = 3'd5; instr_br_depth = 4'd5; instr_valid = 1'b1;
        t = cyc; p0 = pops_seen;
        @(posedge clk); #1 instr_valid = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b1; #1;
        check_val("rst_mid_pop", cs_pop, 0);
        @(negedge clk); #1;
        rst = 1'b0;
        ref_q.delete();
        check_val("rst_mid_cyc", cyc - t, 3);
        check_val("rst_mid_ready", instr_ready, 1);
        check_val("rst_mid_outs", {jump_valid, done, err, jump_addr}, 0);
        instr_op = 3'd7; instr_addr = 8'h99; vs_tag = 4'h2; instr_ret_num = 1'b0; instr_valid = 1'b1;
        #1 check_val("rst_mid_call", {cs_push, cs_function_call}, 2'b11);
        @(posedge clk); #1 instr_valid = 1'b0;
        check_val("rst_mid_pops", pops_seen - p0, 1);
        ref_q.push_back(mk_frame(1, 0, 2, 'h99));
        @(negedge clk); #1;
        check_val("rst_mid_depth", q.size(), 1);
        exec(4, 0, 0, 0, 0, h);

        // Randomized episodes.
        for (int ep = 0; ep < 25; ep++) begin
            do_reset();
            exec(7, $urandom_range(0, 255), $urandom_range(0, 1), 0, $urandom_range(0, 15), h);
            for (int i = 0; i < 30 && !h; i++) begin
                sz = ref_q.size();
                op = $urandom_range(0, 9);
                if (op > 7) op = $urandom_range(1, 3);
                exec(op, $urandom_range(0, 255), $urandom_range(0, 1),
                     $urandom_range(0, sz + 1 > 15 ? 15 : sz + 1), $urandom_range(0, 15), h);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
